// File: rtl/maxpool_pkg.sv
// Shared constants and the signed/unsigned max helper for the max-pool stream.
package maxpool_pkg;
  localparam int DEF_BITS = 8;
  localparam int DEF_POOL = 2;
  localparam int MAX_BITS = 64;

  // Signed compare is done as unsigned after flipping the sign bit of both operands.
  function automatic logic [MAX_BITS-1:0] max_sel(input logic [MAX_BITS-1:0] a,
                                                  input logic [MAX_BITS-1:0] b,
                                                  input logic sgn,
                                                  input int bits);
    logic [MAX_BITS-1:0] flip;
    flip = sgn ? (MAX_BITS'(1) << (bits - 1)) : '0;
    return ((a ^ flip) > (b ^ flip)) ? a : b;
  endfunction
endpackage

// File: rtl/pool_max2.sv
// Combinational two-input max, unsigned or two's-complement.
module pool_max2
  import maxpool_pkg::*;
#(
  parameter int BITS   = DEF_BITS,
  parameter bit SIGNED = 1'b0
) (
  input  logic [BITS-1:0] i_a,
  input  logic [BITS-1:0] i_b,
  output logic [BITS-1:0] o_y
);
  assign o_y = BITS'(max_sel(MAX_BITS'(i_a), MAX_BITS'(i_b), SIGNED, BITS));
endmodule

// File: rtl/maxpool_stream.sv
// Streaming KxK / stride-K max pooling over raster-order frames with a
// single-entry output register and valid/ready flow control on both sides.
module maxpool_stream
  import maxpool_pkg::*;
#(
  parameter int BITS   = DEF_BITS,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int POOL   = DEF_POOL,
  parameter bit SIGNED = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] out_data,
  output logic            out_last
);
  localparam int NWIN = IMG_W / POOL;
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW   = $clog2(POOL);
  localparam int XW   = (NWIN > 1) ? $clog2(NWIN) : 1;

  if ((IMG_W % POOL) != 0 || (IMG_H % POOL) != 0 || POOL < 2 || BITS > MAX_BITS) begin : g_bad_cfg
    $error("maxpool_stream: IMG_W/IMG_H must be multiples of POOL, POOL>=2");
  end

  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [PW-1:0]   r_cph, r_rph;
  logic [XW-1:0]   r_cidx;
  logic [BITS-1:0] r_hmax;
  logic [BITS-1:0] r_lbuf [NWIN];
  logic            r_ovld, r_olast;
  logic [BITS-1:0] r_odata;

  logic            w_acc, w_hend, w_vend, w_col_end, w_row_end;
  logic [BITS-1:0] w_hm, w_hnew, w_lb, w_vm;

  assign in_ready  = !r_ovld || out_ready;
  assign w_acc     = in_valid && in_ready;
  assign w_hend    = (r_cph == PW'(POOL - 1));
  assign w_vend    = (r_rph == PW'(POOL - 1));
  assign w_col_end = (r_col == CW'(IMG_W - 1));
  assign w_row_end = (r_row == RW'(IMG_H - 1));
  assign w_hnew    = (r_cph == '0) ? in_data : w_hm;
  assign w_lb      = r_lbuf[r_cidx];

  pool_max2 #(.BITS(BITS), .SIGNED(SIGNED)) u_hmax (.i_a(r_hmax), .i_b(in_data), .o_y(w_hm));
  pool_max2 #(.BITS(BITS), .SIGNED(SIGNED)) u_vmax (.i_a(w_lb),   .i_b(w_hnew),  .o_y(w_vm));

  // Position counters; the phase/index counters avoid % and / in hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_cph  <= '0;
      r_rph  <= '0;
      r_cidx <= '0;
      r_hmax <= '0;
    end else if (w_acc) begin
      r_hmax <= w_hnew;
      r_col  <= w_col_end ? '0 : r_col + CW'(1);
      r_cph  <= w_hend ? '0 : r_cph + PW'(1);
      if (w_col_end)   r_cidx <= '0;
      else if (w_hend) r_cidx <= r_cidx + XW'(1);
      if (w_col_end) begin
        r_row <= w_row_end ? '0 : r_row + RW'(1);
        r_rph <= w_vend ? '0 : r_rph + PW'(1);
      end
    end
  end

  // Line buffer needs no reset: the first row of each window band overwrites it.
  always_ff @(posedge clk) begin
    if (!rst && w_acc && w_hend)
      r_lbuf[r_cidx] <= (r_rph == '0) ? w_hnew : w_vm;
  end

  // A completed window can only be accepted when the output slot is free or draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovld  <= 1'b0;
      r_olast <= 1'b0;
      r_odata <= '0;
    end else if (w_acc && w_hend && w_vend) begin
      r_ovld  <= 1'b1;
      r_odata <= w_vm;
      r_olast <= w_col_end && w_row_end;
    end else if (out_ready) begin
      r_ovld  <= 1'b0;
    end
  end

  assign out_valid = r_ovld;
  assign out_data  = r_odata;
  assign out_last  = r_olast;
endmodule

// File: tb/tb_maxpool_stream.sv
// Self-checking bench for maxpool_stream: directed frames plus randomized
// frames/back-pressure against a window-level reference model.
module tb_maxpool_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       iv = 1'b0;
  logic [7:0] id = '0;
  logic       ord = 1'b1;
  int         sel = 0;

  logic a_iv, a_ir, a_ov, a_ol; logic [7:0] a_od;
  logic b_iv, b_ir, b_ov, b_ol; logic [7:0] b_od;
  logic c_iv, c_ir, c_ov, c_ol; logic [7:0] c_od;
  logic cur_ir, cur_ov, cur_ol; logic [7:0] cur_od;

  assign a_iv = iv && (sel == 0);
  assign b_iv = iv && (sel == 1);
  assign c_iv = iv && (sel == 2);

  maxpool_stream #(.BITS(8), .IMG_W(4), .IMG_H(4), .POOL(2), .SIGNED(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_ir), .in_data(id),
    .out_valid(a_ov), .out_ready(ord), .out_data(a_od), .out_last(a_ol));
  maxpool_stream #(.BITS(8), .IMG_W(4), .IMG_H(2), .POOL(2), .SIGNED(1)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir), .in_data(id),
    .out_valid(b_ov), .out_ready(ord), .out_data(b_od), .out_last(b_ol));
  maxpool_stream #(.BITS(8), .IMG_W(6), .IMG_H(3), .POOL(3), .SIGNED(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_ir), .in_data(id),
    .out_valid(c_ov), .out_ready(ord), .out_data(c_od), .out_last(c_ol));

  always_comb begin
    cur_ir = a_ir; cur_ov = a_ov; cur_ol = a_ol; cur_od = a_od;
    if (sel == 1) begin cur_ir = b_ir; cur_ov = b_ov; cur_ol = b_ol; cur_od = b_od; end
    if (sel == 2) begin cur_ir = c_ir; cur_ov = c_ov; cur_ol = c_ol; cur_od = c_od; end
  end

  int n_cmp = 0, n_err = 0;
  int exp_q[$], obs_q[$];
  int ord_mode = 0, bubble_max = 0;
  int stall_cnt = 0, ready_bad = 0, hold_bad = 0;
  bit p_stall = 1'b0;
  logic [8:0] p_out = '0;

  // One cycle starting at a negedge: drive, sample the handshakes, advance.
  task automatic step(input bit v, input logic [7:0] d, output bit acc);
    iv = v; id = d;
    case (ord_mode)
      0:       ord = 1'b1;
      1:       ord = ~ord;
      default: ord = ($urandom_range(0, 99) < 60);
    endcase
    #1;
    if (cur_ir !== (!cur_ov || ord)) ready_bad++;
    if (p_stall && (cur_ov !== 1'b1 || {cur_ol, cur_od} !== p_out)) hold_bad++;
    acc = v && cur_ir;
    if (v && !acc) stall_cnt++;
    if (cur_ov && ord) obs_q.push_back(int'({cur_ol, cur_od}));
    p_stall = cur_ov && !ord;
    p_out   = {cur_ol, cur_od};
    @(negedge clk);
  endtask

  task automatic send_frame(input int pix[$]);
    bit acc;
    foreach (pix[i]) begin
      int tries = 0;
      repeat ($urandom_range(0, bubble_max)) step(1'b0, 8'($urandom), acc);
      do begin
        step(1'b1, 8'(pix[i]), acc);
        tries++;
      end while (!acc && tries < 100);
      if (!acc) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout pixel %0d not accepted within 100 cycles, required accept", i);
      end
    end
  endtask

  task automatic drain();
    bit acc;
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 200) begin step(1'b0, 8'h00, acc); n++; end
    repeat (4) step(1'b0, 8'h00, acc);
  endtask

  task automatic do_reset();
    rst = 1'b1; iv = 1'b0; ord = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    p_stall = 1'b0;
    exp_q.delete(); obs_q.delete();
    stall_cnt = 0; ready_bad = 0; hold_bad = 0;
  endtask

  // Window-level reference: max of each KxK block, last flag on the final block.
  task automatic model_frame(input int pix[$], input int w, input int h, input int k, input bit sgn);
    for (int wy = 0; wy < h / k; wy++)
      for (int wx = 0; wx < w / k; wx++) begin
        int best = -1000, bv = 0;
        for (int dy = 0; dy < k; dy++)
          for (int dx = 0; dx < k; dx++) begin
            int p = pix[(wy * k + dy) * w + wx * k + dx];
            int s = (sgn && p >= 128) ? p - 256 : p;
            if (s > best) begin best = s; bv = p; end
          end
        exp_q.push_back(bv | ((wy == h / k - 1 && wx == w / k - 1) ? 256 : 0));
      end
  endtask

  function automatic void ramp(output int q[$], input int n, input bit down);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(down ? n - 1 - i : i);
  endfunction

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", a_ov); end
    n_cmp++; if (a_ol !== 1'b0) begin n_err++; $display("FAIL reset_out_last got %b want 0", a_ol); end
    n_cmp++; if (a_od !== 8'h00) begin n_err++; $display("FAIL reset_out_data got %0h want 0", a_od); end
    n_cmp++; if (a_ir !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", a_ir); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    int pix[$];
    sel = 0; ord_mode = 0; bubble_max = 0;
    exp_q = '{5, 7, 13, 271}; obs_q.delete();
    ramp(pix, 16, 1'b0);
    send_frame(pix); drain();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] != exp_q[i]) begin n_err++; $display("FAIL basic_out[%0d] got %0h want %0h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    int pix[$];
    sel = 0; ord_mode = 1; bubble_max = 0;
    exp_q = '{5, 7, 13, 271}; obs_q.delete();
    stall_cnt = 0; ready_bad = 0; hold_bad = 0;
    ramp(pix, 16, 1'b0);
    send_frame(pix); drain();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL stall_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] != exp_q[i]) begin n_err++; $display("FAIL stall_out[%0d] got %0h want %0h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (ready_bad != 0) begin n_err++; $display("FAIL stall_in_ready cycles_wrong got %0d want 0", ready_bad); end
    n_cmp++; if (hold_bad != 0) begin n_err++; $display("FAIL stall_hold cycles_unstable got %0d want 0", hold_bad); end
  endtask

  task automatic test_back_to_back();
    int pix[$];
    sel = 0; ord_mode = 0; bubble_max = 0;
    exp_q = '{5, 7, 13, 271, 15, 13, 7, 261}; obs_q.delete();
    stall_cnt = 0;
    ramp(pix, 16, 1'b0);
    for (int i = 15; i >= 0; i--) pix.push_back(i);
    send_frame(pix); drain();
    n_cmp++; if (stall_cnt != 0) begin n_err++; $display("FAIL b2b_gap stalled_cycles got %0d want 0", stall_cnt); end
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] != exp_q[i]) begin n_err++; $display("FAIL b2b_out[%0d] got %0h want %0h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_signed();
    int pix[$];
    sel = 1; ord_mode = 0; bubble_max = 0;
    pix = '{8'hFF, 8'h01, 8'h10, 8'h20, 8'h80, 8'h00, 8'hF0, 8'hE0};
    exp_q = '{8'h01, 9'h120}; obs_q.delete();
    send_frame(pix); drain();
    sel = 0;
    pix = '{8'hFF, 8'h01, 0, 0, 8'h80, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_q.push_back(8'hFF); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(256);
    send_frame(pix); drain();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL signed_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] != exp_q[i]) begin n_err++; $display("FAIL signed_out[%0d] got %0h want %0h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int pix[$];
    sel = 0; ord_mode = 0; bubble_max = 0;
    ramp(pix, 6, 1'b0);
    send_frame(pix);
    do_reset();
    #1;
    n_cmp++; if (a_ov !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid got %b want 0", a_ov); end
    @(negedge clk);
    exp_q = '{5, 7, 13, 271};
    ramp(pix, 16, 1'b0);
    send_frame(pix); drain();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rstmid_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] != exp_q[i]) begin n_err++; $display("FAIL rstmid_out[%0d] got %0h want %0h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_pool3();
    int pix[$];
    sel = 2; ord_mode = 0; bubble_max = 0;
    exp_q = '{14, 273}; obs_q.delete();
    ramp(pix, 18, 1'b0);
    send_frame(pix); drain();
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL pool3_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] != exp_q[i]) begin n_err++; $display("FAIL pool3_out[%0d] got %0h want %0h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int pix[$];
    int w[3] = '{4, 4, 6};
    int h[3] = '{4, 2, 3};
    int k[3] = '{2, 2, 3};
    ord_mode = 2; bubble_max = 2;
    for (int d = 0; d < 3; d++) begin
      sel = d;
      exp_q.delete(); obs_q.delete();
      ready_bad = 0; hold_bad = 0;
      for (int f = 0; f < 4; f++) begin
        pix.delete();
        for (int i = 0; i < w[d] * h[d]; i++) pix.push_back(int'($urandom_range(0, 255)));
        model_frame(pix, w[d], h[d], k[d], d == 1);
        send_frame(pix);
      end
      drain();
      n_cmp++; if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL rand%0d_count got %0d want %0d", d, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_cmp++; if (obs_q[i] != exp_q[i]) begin n_err++; $display("FAIL rand%0d_out[%0d] got %0h want %0h", d, i, obs_q[i], exp_q[i]); end
      end
      n_cmp++; if (ready_bad != 0) begin n_err++; $display("FAIL rand%0d_in_ready cycles_wrong got %0d want 0", d, ready_bad); end
      n_cmp++; if (hold_bad != 0) begin n_err++; $display("FAIL rand%0d_hold cycles_unstable got %0d want 0", d, hold_bad); end
    end
    ord_mode = 0; bubble_max = 0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_signed();
    test_reset_mid();
    test_pool3();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/maxpool_stream.md
MAXPOOL_STREAM -- requirements
Module: maxpool_stream

Interface
REQ-001 Parameter BITS, default 8, pixel width in bits.
REQ-002 Parameter IMG_W, default 28, input row width in pixels.
REQ-003 Parameter IMG_H, default 28, input frame height in rows.
REQ-004 Parameter POOL, default 2, window side K; stride equals K.
REQ-005 Parameter SIGNED, default 0, comparison mode: 0 unsigned, 1 two's-complement.
REQ-006 clk  input  1  single clock; all logic is on the rising edge.
REQ-007 rst  input  1  reset, synchronous and active-high.
REQ-008 in_valid  input  1  in_data holds a valid pixel.
REQ-009 in_ready  output  1  block accepts a pixel this cycle.
REQ-010 in_data  input  BITS  pixel, raster order (row-major, frame after frame).
REQ-011 out_valid  output  1  out_data holds a valid pooled pixel.
REQ-012 out_ready  input  1  downstream accepts the output this cycle.
REQ-013 out_data  output  BITS  max of one KxK window.
REQ-014 out_last  output  1  qualifies the final pooled pixel of a frame.

Function
REQ-015 A transfer SHALL occur on a side only when valid and ready are both high at the clock edge.
REQ-016 Elaboration SHALL fail unless IMG_W%POOL==0, IMG_H%POOL==0 and POOL>=2.
REQ-017 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL advance once per accepted pixel; col wraps to 0 and increments row; row wraps to 0 after the last frame pixel.
REQ-018 Horizontal accumulator hmax SHALL load in_data when col%POOL==0 and otherwise take max(hmax, in_data).
REQ-019 Line buffer lbuf, depth IMG_W/POOL, width BITS: when col%POOL==POOL-1 the horizontal result h is formed; lbuf[col/POOL] SHALL be written with h if row%POOL==0, else with max(lbuf[col/POOL], h).
REQ-020 When col%POOL==POOL-1 and row%POOL==POOL-1, the output register SHALL load max(lbuf[col/POOL], h) on that edge; out_valid is high the next cycle (latency 1).
REQ-021 out_last SHALL be high with the output produced at col==IMG_W-1, row==IMG_H-1, and low otherwise.
REQ-022 Comparison SHALL be unsigned when SIGNED==0, signed when SIGNED==1; on ties either operand is returned (values are identical).
REQ-023 in_ready SHALL equal !out_valid || out_ready (single-entry output skid); full throughput of one pixel per cycle with out_ready held high.
REQ-024 out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-025 Simultaneous output drain and new window completion in one cycle SHALL reload the output register with no bubble.
REQ-026 A frame boundary SHALL need no idle cycle; pixel 0 of the next frame is accepted directly after the last pixel.

Reset
REQ-027 On rst high at an edge: col=0, row=0, out_valid=0, out_last=0, out_data=0; hmax SHALL reset to 0.
REQ-028 Contents of lbuf are not reset; correctness follows from REQ-019 overwrite on row%POOL==0.
REQ-029 Reset mid-frame SHALL discard the partial frame; the first pixel accepted after reset is treated as frame pixel (0,0).
REQ-030 in_ready SHALL be high in the first cycle after reset.

Structure
REQ-031 Shared package maxpool_pkg SHALL hold the default BITS/POOL constants and a signed/unsigned max function used by both datapath compares.
REQ-032 One sub-module pool_max2 (two BITS inputs, SIGNED parameter, combinational max output) SHALL be instantiated for the horizontal and vertical compares.
REQ-033 lbuf SHALL be a plain register array (no vendor RAM).

Verification
REQ-034 IMG_W=4, IMG_H=4, POOL=2, stream 0..15, out_ready=1 -> outputs 5,7,13,15; out_last only with 15.
REQ-035 Same stream, out_ready toggling 1/0 each cycle -> identical data sequence; in_ready low while output is stalled; no loss or duplication.
REQ-036 SIGNED=1, window {0xFF,0x01,0x80,0x00} -> 0x01; SIGNED=0 same window -> 0xFF.
REQ-037 Two back-to-back frames 0..15 then 15..0 -> 5,7,13,15 then 15,13,7,5 with no gap cycle; out_last on the 4th and 8th outputs.
REQ-038 rst asserted after 6 pixels of a frame, then stream 0..15 -> exactly 5,7,13,15; no stale output.
REQ-039 IMG_W=6, IMG_H=3, POOL=3, stream 0..17 -> outputs 14,17, out_last with 17.
